settle_sampler: RTL and testbench
=================================

Name: settle_sampler

Overview:
- Clocked reader-side observer for a driven signal (net or variable).
- Samples `din` once per clock edge and treats only the value settled at that edge as meaningful. Intra-timestep writes such as 0 then 1 are invisible by construction.
- Each sampled value change becomes an event {old, new, timestamp}, queued in a small FIFO and handed to a consumer over valid/ready.
- Sits beside example writer blocks as the checker/consumer end in bench-style examples.

Parameters:
- WIDTH, 1: width of the observed signal.
- DEPTH, 4: event FIFO entries; power of two, >= 2.
- TS_WIDTH, 8: timestamp counter width; wraps modulo 2^TS_WIDTH.
- CNT_WIDTH, 8: change counter width; saturating.

Ports:
- clk  input  1  sampling clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  observed signal, sampled at rising clk.
- evt_valid  output  1  FIFO non-empty; head event presented.
- evt_ready  input  1  consumer accepts head when evt_valid && evt_ready at rising clk.
- evt_old  output  WIDTH  previous settled value of head event.
- evt_new  output  WIDTH  new settled value of head event.
- evt_ts  output  TS_WIDTH  timestamp of the edge where the change was sampled.
- overflow  output  1  sticky; an event was dropped because the FIFO was full.
- chg_count  output  CNT_WIDTH  number of sampled changes since reset, saturating.

Behaviour:
- Reset (async, rst=1), effective immediately:
  - FIFO emptied; evt_valid=0.
  - evt_old/evt_new/evt_ts = 0.
  - overflow=0, chg_count=0, ts counter=0.
  - FSM -> PRIME, prev=0.
- Reset deasserted mid-stream: restart from PRIME. No event is generated for the value difference across reset.
- ts counter increments every rising edge while not in reset. At 2^TS_WIDTH-1 it wraps to 0.
- FSM, state PRIME:
  - First edge after reset: prev <= din; no event, chg_count unchanged.
  - Next state RUN.
- FSM, state RUN, each edge:
  - din == prev: nothing.
  - din != prev: change detected. prev <= din; chg_count += 1, saturating at 2^CNT_WIDTH-1.
  - Event {old=prev, new=din, ts=current ts value before increment} is pushed.
  - RUN has no exit except reset.
- FIFO:
  - DEPTH entries, circular read/write pointers plus occupancy count.
  - Pop occurs when evt_valid && evt_ready at the edge.
  - Outputs show the head entry combinationally from storage. When empty, outputs hold the last popped values, or 0 after reset. Bench checks them only when evt_valid=1.
- Latency:
  - Change sampled at edge k, FIFO previously empty: evt_valid=1 after edge k.
  - Consumer can pop at edge k+1.
- Simultaneous push and pop:
  - Not full: occupancy unchanged; order preserved.
  - Full: pop frees the slot, push accepted, no overflow.
- Full with push and no pop:
  - Event dropped; overflow <= 1, held until reset.
  - prev and chg_count still update; FIFO contents unchanged.
- Empty with evt_ready=1: no effect.
- Events always leave in sample order. Timestamps are not adjusted for wrap; consumers compare modulo 2^TS_WIDTH.
- din X/Z is not a supported stimulus; behaviour is undefined.

Test Plan:
1. Reset, then hold din=0 for 10 edges with evt_ready=1 -> evt_valid stays 0, chg_count=0, overflow=0.
2. Reset, prime with din=0, then din=1 at the edge where ts=3 -> one event old=0, new=1, ts=3, visible the cycle after that edge; chg_count=1. Two writes 0 then 1 in the same timestep before an edge -> exactly one event, new=1.
3. evt_ready=0; toggle din on 5 consecutive edges with DEPTH=4 -> 4 events queued with alternating values and increasing ts, overflow=1, chg_count=5. Then evt_ready=1 -> 4 pops in order, then evt_valid=0.
4. FIFO full, din toggles at the same edge evt_ready=1 -> head popped, new event accepted, overflow stays 0, occupancy stays 4.
5. Assert rst asynchronously (between edges) with 2 events queued and overflow=1 -> outputs clear immediately. After release, the first edge primes with no event even if din differs from the pre-reset value.
6. TS_WIDTH=8: change at ts=255, then another at the next edge -> events carry ts=255 then ts=0. With CNT_WIDTH=2, 5 changes -> chg_count saturates at 3.

Source files
------------

// File: rtl/settle_sampler.sv
// -----------------------------------------------------------------------------
// settle_sampler
//
// Reader-side observer for a driven signal. The observed signal is sampled on
// every rising clock edge. Only the value settled at that edge counts, so
// several writes inside one timestep can produce at most one change.
//
// Each sampled change becomes an event {old, new, timestamp}. Events are
// queued in a small FIFO and handed to a consumer over a valid/ready pair.
//
// Ports:
//   clk        sampling clock, rising edge
//   rst        asynchronous, active-high reset
//   din        observed signal (WIDTH bits)
//   evt_valid  FIFO non-empty; the head event is presented
//   evt_ready  consumer takes the head when evt_valid && evt_ready at an edge
//   evt_old    previous settled value of the head event
//   evt_new    new settled value of the head event
//   evt_ts     timestamp of the edge where the change was sampled
//   overflow   sticky; an event was dropped because the FIFO was full
//   chg_count  saturating count of sampled changes since reset
//
// Parameters:
//   WIDTH      width of the observed signal
//   DEPTH      FIFO entries; must be a power of two and >= 2
//   TS_WIDTH   timestamp counter width; the counter wraps
//   CNT_WIDTH  change counter width; the counter saturates
// -----------------------------------------------------------------------------
module settle_sampler #(
   parameter int WIDTH     = 1,
   parameter int DEPTH     = 4,
   parameter int TS_WIDTH  = 8,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     din,
   output logic                 evt_valid,
   input  logic                 evt_ready,
   output logic [WIDTH-1:0]     evt_old,
   output logic [WIDTH-1:0]     evt_new,
   output logic [TS_WIDTH-1:0]  evt_ts,
   output logic                 overflow,
   output logic [CNT_WIDTH-1:0] chg_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(DEPTH);

   typedef enum logic {PRIME, RUN} state_t;

   state_t               state_reg;
   logic [WIDTH-1:0]     prev_reg;
   logic [TS_WIDTH-1:0]  ts_reg;
   logic [CNT_WIDTH-1:0] cnt_reg;
   logic                 overflow_reg;

   logic [PTR_W-1:0]     rd_ptr_reg;
   logic [PTR_W-1:0]     wr_ptr_reg;
   logic [PTR_W:0]       occ_reg;

   // Last popped values, shown while the FIFO is empty.
   logic [WIDTH-1:0]     last_old_reg;
   logic [WIDTH-1:0]     last_new_reg;
   logic [TS_WIDTH-1:0]  last_ts_reg;

   logic [WIDTH-1:0]     mem_old [DEPTH];
   logic [WIDTH-1:0]     mem_new [DEPTH];
   logic [TS_WIDTH-1:0]  mem_ts  [DEPTH];

   logic change;
   logic empty;
   logic full;
   logic pop;
   logic push;
   logic drop;

   always_comb begin
      change = (state_reg == RUN) && (din != prev_reg);
      empty  = (occ_reg == '0);
      full   = (occ_reg == FULL_OCC);
      pop    = !empty && evt_ready;
      // A pop in the same edge frees a slot, so a full FIFO still accepts.
      push   = change && (!full || pop);
      drop   = change && full && !pop;
   end

   // Sampler FSM, counters and FIFO bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= PRIME;
         prev_reg     <= '0;
         ts_reg       <= '0;
         cnt_reg      <= '0;
         overflow_reg <= 1'b0;
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         occ_reg      <= '0;
         last_old_reg <= '0;
         last_new_reg <= '0;
         last_ts_reg  <= '0;
      end else begin
         ts_reg <= ts_reg + TS_WIDTH'(1);

         case (state_reg)
            PRIME: begin
               // Establish the reference value; nothing to compare against yet.
               prev_reg  <= din;
               state_reg <= RUN;
            end
            RUN: begin
               if (change) begin
                  prev_reg <= din;
                  if (cnt_reg != '1) begin
                     cnt_reg <= cnt_reg + CNT_WIDTH'(1);
                  end
               end
            end
            default: state_reg <= PRIME;
         endcase

         if (drop) begin
            overflow_reg <= 1'b1;
         end

         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end

         if (pop) begin
            rd_ptr_reg   <= rd_ptr_reg + PTR_W'(1);
            last_old_reg <= mem_old[rd_ptr_reg];
            last_new_reg <= mem_new[rd_ptr_reg];
            last_ts_reg  <= mem_ts[rd_ptr_reg];
         end

         case ({push, pop})
            2'b10:   occ_reg <= occ_reg + (PTR_W+1)'(1);
            2'b01:   occ_reg <= occ_reg - (PTR_W+1)'(1);
            default: occ_reg <= occ_reg;
         endcase
      end
   end

   // Event storage. Contents are only observed while occupied, so it needs no
   // reset and can map onto distributed memory.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_old[wr_ptr_reg] <= prev_reg;
         mem_new[wr_ptr_reg] <= din;
         mem_ts[wr_ptr_reg]  <= ts_reg;
      end
   end

   always_comb begin
      evt_valid = !empty;
      if (empty) begin
         evt_old = last_old_reg;
         evt_new = last_new_reg;
         evt_ts  = last_ts_reg;
      end else begin
         evt_old = mem_old[rd_ptr_reg];
         evt_new = mem_new[rd_ptr_reg];
         evt_ts  = mem_ts[rd_ptr_reg];
      end
      overflow  = overflow_reg;
      chg_count = cnt_reg;
   end

endmodule

// File: tb/tb_settle_sampler.sv
// -----------------------------------------------------------------------------
// tb_settle_sampler
//
// Directed bench for settle_sampler. A vector table drives din/evt_ready one
// edge at a time and lists the expected outputs after each edge. Hand-written
// sequences cover the asynchronous reset, same-timestep writes, timestamp wrap
// and counter saturation. A second instance with CNT_WIDTH=2 shares the stimulus.
// -----------------------------------------------------------------------------
module tb_settle_sampler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [0:0] din = 1'b0;
   logic       evt_ready = 1'b0;

   logic       evt_valid;
   logic [0:0] evt_old;
   logic [0:0] evt_new;
   logic [7:0] evt_ts;
   logic       overflow;
   logic [7:0] chg_count;

   logic       s_valid;
   logic [0:0] s_old;
   logic [0:0] s_new;
   logic [7:0] s_ts;
   logic       s_overflow;
   logic [1:0] s_chg_count;

   int checks   = 0;
   int failures = 0;

   settle_sampler #(.WIDTH(1), .DEPTH(4), .TS_WIDTH(8), .CNT_WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_old   (evt_old),
      .evt_new   (evt_new),
      .evt_ts    (evt_ts),
      .overflow  (overflow),
      .chg_count (chg_count)
   );

   settle_sampler #(.WIDTH(1), .DEPTH(4), .TS_WIDTH(8), .CNT_WIDTH(2)) dut_sat (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .evt_valid (s_valid),
      .evt_ready (evt_ready),
      .evt_old   (s_old),
      .evt_new   (s_new),
      .evt_ts    (s_ts),
      .overflow  (s_overflow),
      .chg_count (s_chg_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit   rst_b;
      logic din;
      logic rdy;
      logic v;
      logic old_v;
      logic new_v;
      int   ts;
      logic ovf;
      int   cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit rb, input logic d, input logic r, input logic v,
                      input logic o, input logic n, input int ts,
                      input logic ovf, input int cnt);
      vec_t e;
      e.rst_b = rb; e.din = d; e.rdy = r; e.v = v; e.old_v = o; e.new_v = n;
      e.ts = ts; e.ovf = ovf; e.cnt = cnt;
      tbl.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called 1 time unit after an edge; asserts reset between edges and
   // releases it on the falling edge.
   task automatic pulse_reset();
      #2 rst = 1'b1;
      #2 rst = 1'b0;
   endtask

   initial begin
      @(posedge clk);
      #1;

      // Reset state, checked before any edge after release.
      pulse_reset();
      chk("reset_valid", evt_valid, 0);
      chk("reset_ovf", overflow, 0);
      chk("reset_cnt", chg_count, 0);
      chk("reset_old", evt_old, 0);
      chk("reset_new", evt_new, 0);
      chk("reset_ts", evt_ts, 0);
      $display("reset state checked");

      // Quiet input: nothing reported.
      for (int k = 0; k < 10; k++) add(k == 0, 0, 1, 0, 0, 0, 0, 0, 0);
      // Single change at ts=3, then popped.
      add(1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 1, 0, 1, 3, 0, 1);
      add(0, 1, 1, 0, 0, 0, 0, 0, 1);
      // Five toggles with no consumer: four queued, one dropped.
      add(1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 1, 0, 1, 1, 0, 1);
      add(0, 0, 0, 1, 0, 1, 1, 0, 2);
      add(0, 1, 0, 1, 0, 1, 1, 0, 3);
      add(0, 0, 0, 1, 0, 1, 1, 0, 4);
      add(0, 1, 0, 1, 0, 1, 1, 1, 5);
      add(0, 1, 1, 1, 1, 0, 2, 1, 5);
      add(0, 1, 1, 1, 0, 1, 3, 1, 5);
      add(0, 1, 1, 1, 1, 0, 4, 1, 5);
      add(0, 1, 1, 0, 0, 0, 0, 1, 5);
      // Full FIFO, push and pop on the same edge: no drop, still four deep.
      add(1, 1, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 1, 1, 0, 1, 0, 1);
      add(0, 1, 0, 1, 1, 0, 1, 0, 2);
      add(0, 0, 0, 1, 1, 0, 1, 0, 3);
      add(0, 1, 0, 1, 1, 0, 1, 0, 4);
      add(0, 0, 1, 1, 0, 1, 2, 0, 5);
      add(0, 0, 1, 1, 1, 0, 3, 0, 5);
      add(0, 0, 1, 1, 0, 1, 4, 0, 5);
      add(0, 0, 1, 1, 1, 0, 5, 0, 5);
      add(0, 0, 1, 0, 0, 0, 0, 0, 5);

      foreach (tbl[i]) begin
         if (tbl[i].rst_b) pulse_reset();
         din       = tbl[i].din;
         evt_ready = tbl[i].rdy;
         step();
         chk($sformatf("v%0d_valid", i), evt_valid, tbl[i].v);
         chk($sformatf("v%0d_ovf", i), overflow, tbl[i].ovf);
         chk($sformatf("v%0d_cnt", i), chg_count, tbl[i].cnt);
         if (tbl[i].v) begin
            chk($sformatf("v%0d_old", i), evt_old, tbl[i].old_v);
            chk($sformatf("v%0d_new", i), evt_new, tbl[i].new_v);
            chk($sformatf("v%0d_ts", i), evt_ts, tbl[i].ts);
         end
         $display("vec %0d din=%0d rdy=%0d valid=%0d old=%0d new=%0d ts=%0d ovf=%0d cnt=%0d",
                  i, din, evt_ready, evt_valid, evt_old, evt_new, evt_ts, overflow, chg_count);
      end

      // Asynchronous reset with two events queued and overflow set.
      pulse_reset();
      din = 0; evt_ready = 0;
      step();
      for (int k = 1; k <= 5; k++) begin
         din = ~din;
         step();
      end
      evt_ready = 1;
      step();
      step();
      evt_ready = 0;
      chk("pre_rst_valid", evt_valid, 1);
      chk("pre_rst_ovf", overflow, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_valid", evt_valid, 0);
      chk("async_ovf", overflow, 0);
      chk("async_cnt", chg_count, 0);
      chk("async_ts", evt_ts, 0);
      $display("async reset valid=%0d ovf=%0d cnt=%0d", evt_valid, overflow, chg_count);
      din = 0;
      #1 rst = 1'b0;
      step();
      chk("prime_valid", evt_valid, 0);
      chk("prime_cnt", chg_count, 0);
      step();
      chk("post_prime_valid", evt_valid, 0);
      din = 1;
      step();
      chk("post_rst_valid", evt_valid, 1);
      chk("post_rst_new", evt_new, 1);
      chk("post_rst_ts", evt_ts, 2);
      $display("post reset event valid=%0d new=%0d ts=%0d", evt_valid, evt_new, evt_ts);

      // Two writes in one timestep: only the settled value is seen.
      pulse_reset();
      din = 0; evt_ready = 0;
      step();
      din = 0;
      din = 1;
      step();
      chk("glitch_valid", evt_valid, 1);
      chk("glitch_old", evt_old, 0);
      chk("glitch_new", evt_new, 1);
      chk("glitch_ts", evt_ts, 1);
      chk("glitch_cnt", chg_count, 1);
      evt_ready = 1;
      step();
      chk("glitch_single", evt_valid, 0);
      $display("same-timestep writes cnt=%0d", chg_count);

      // Timestamp wrap.
      pulse_reset();
      din = 0; evt_ready = 0;
      repeat (255) step();
      din = 1;
      step();
      chk("wrap_ts255", evt_ts, 255);
      din = 0;
      step();
      chk("wrap_hold_ts", evt_ts, 255);
      chk("wrap_cnt", chg_count, 2);
      evt_ready = 1;
      step();
      chk("wrap_valid", evt_valid, 1);
      chk("wrap_ts0", evt_ts, 0);
      chk("wrap_new", evt_new, 0);
      step();
      chk("wrap_empty", evt_valid, 0);
      $display("timestamp wrap checked ts=%0d", evt_ts);

      // Change counter saturation on the CNT_WIDTH=2 instance.
      pulse_reset();
      chk("sat_reset", s_chg_count, 0);
      din = 0; evt_ready = 0;
      step();
      for (int k = 1; k <= 5; k++) begin
         din = ~din;
         step();
         chk($sformatf("sat_cnt%0d", k), s_chg_count, (k < 3) ? k : 3);
         chk($sformatf("wide_cnt%0d", k), chg_count, k);
         $display("saturation change %0d cnt2=%0d cnt8=%0d", k, s_chg_count, chg_count);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Safety net in case anything above stalls.
   initial begin
      #200000;
      $display("FAIL timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
